// File: rtl/addsub_pipe32_pkg.sv
// rtl/addsub_pipe32_pkg.sv - shared widths, opcodes and saturation constants for the add/sub pipeline
package addsub_pipe32_pkg;

    localparam int ADDSUB_W = 32;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    localparam logic [ADDSUB_W-1:0] ADDSUB_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [ADDSUB_W-1:0] ADDSUB_SAT_MIN = 32'h8000_0000;

    // Clamp value for an overflowed result: overflow direction follows the sign of operand a
    function automatic logic [ADDSUB_W-1:0] sat_value(input logic a_sign);
        return a_sign ? ADDSUB_SAT_MIN : ADDSUB_SAT_MAX;
    endfunction

endpackage

// File: rtl/adder_substractor32.sv
// rtl/adder_substractor32.sv - combinational 32-bit adder/subtractor with signed overflow and carry
module adder_substractor32
    import addsub_pipe32_pkg::*;
(
    input  logic [ADDSUB_W-1:0] a,
    input  logic [ADDSUB_W-1:0] b,
    input  logic                m,
    output logic [ADDSUB_W-1:0] s,
    output logic                v,
    output logic                c
);

    logic [ADDSUB_W-1:0] b_eff;
    logic [ADDSUB_W:0]   sum;

    // Subtract is a + ~b + 1; the mode bit doubles as the carry-in
    assign b_eff = (m == ADDSUB_OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{ADDSUB_W{1'b0}}, m};
    assign s     = sum[ADDSUB_W-1:0];
    assign c     = sum[ADDSUB_W];

    // Overflow: effective operands share a sign and the result sign differs from it
    assign v = (a[ADDSUB_W-1] == b_eff[ADDSUB_W-1]) && (s[ADDSUB_W-1] != a[ADDSUB_W-1]);

endmodule

// File: rtl/addsub_pipe32.sv
// rtl/addsub_pipe32.sv - two-stage valid/ready add/sub pipeline with overflow counter; optional ADDSUB_SAT_EN
module addsub_pipe32
    import addsub_pipe32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDSUB_W-1:0] in_a,
    input  logic [ADDSUB_W-1:0] in_b,
    input  logic                in_m,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDSUB_W-1:0] out_s,
    output logic                out_v,
    output logic                out_c,
    output logic [CNT_W-1:0]    ovf_cnt
);

    logic                s1_valid;
    logic [ADDSUB_W-1:0] s1_a;
    logic [ADDSUB_W-1:0] s1_b;
    logic                s1_m;

    logic                adv1;
    logic                adv2;

    logic [ADDSUB_W-1:0] add_s;
    logic                add_v;
    logic                add_c;
    logic [ADDSUB_W-1:0] s_next;

    // Each stage moves when its downstream slot is empty or being drained this cycle
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    adder_substractor32 u_adder (
        .a (s1_a),
        .b (s1_b),
        .m (s1_m),
        .s (add_s),
        .v (add_v),
        .c (add_c)
    );

`ifdef ADDSUB_SAT_EN
    // Clamp the stored sum on overflow; flags still carry the raw adder result
    assign s_next = add_v ? sat_value(s1_a[ADDSUB_W-1]) : add_s;
`else
    assign s_next = add_s;
`endif

    // Stage 1: capture operands whenever the stage can advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_m     <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_m     <= in_m;
        end
    end

    // Stage 2: register adder result for the consumer; payload only changes on a real op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_v     <= 1'b0;
            out_c     <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_s <= s_next;
                out_v <= add_v;
                out_c <= add_c;
            end
        end
    end

    // Count delivered overflowing results, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && out_v && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_addsub_pipe32.sv
// tb/tb_addsub_pipe32.sv - self-checking bench for addsub_pipe32 (directed cases plus randomized scoreboard)
module tb_addsub_pipe32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_m;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        out_v;
    logic        out_c;
    logic [15:0] ovf_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_s2;
    logic        out_v2;
    logic        out_c2;
    logic [1:0]  ovf_cnt2;

    addsub_pipe32 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_v(out_v), .out_c(out_c),
        .ovf_cnt(ovf_cnt)
    );

    addsub_pipe32 #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_s(out_s2), .out_v(out_v2), .out_c(out_c2),
        .ovf_cnt(ovf_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic        v;
        logic        c;
    } exp_t;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    logic [31:0] got_s[$];
    logic        got_v[$];
    logic        got_c[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    int          exp_cnt16 = 0;
    int          exp_cnt2  = 0;
    int          cyc = 0;
    bit          in_rst = 0;
    bit          hold_pend = 0;
    logic [31:0] hold_s;
    logic        hold_v;
    logic        hold_c;
    bit          rnd_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic on wide integers, carry from unsigned comparisons
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic m);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      r;
        logic [32:0] usum;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        r    = m ? (sa - sb) : (sa + sb);
        usum = {1'b0, a} + {1'b0, b};
        e.v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.c  = m ? (a >= b) : usum[32];
        e.s  = r[31:0];
`ifdef ADDSUB_SAT_EN
        if (e.v) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: sampled on the falling edge, mid-cycle between input drives and the active edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt16 = 0;
            exp_cnt2  = 0;
            hold_pend = 0;
            in_rst    = 1;
        end else begin
            if (in_rst) begin
                check_eq("rst_out_valid", out_valid, 0);
                check_eq("rst_in_ready", in_ready, 1);
                check_eq("rst_in_ready_c2", in_ready2, 1);
                in_rst = 0;
            end
            check_eq("ovf_cnt", ovf_cnt, exp_cnt16);
            check_eq("ovf_cnt_c2", ovf_cnt2, exp_cnt2);
            if (hold_pend) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_s", out_s, hold_s);
                check_eq("hold_flags", {out_v, out_c}, {hold_v, hold_c});
            end
            hold_pend = out_valid && !out_ready;
            hold_s = out_s;
            hold_v = out_v;
            hold_c = out_c;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_s", out_s, e.s);
                    check_eq("sb_v", out_v, e.v);
                    check_eq("sb_c", out_c, e.c);
                    check_eq("sb_c2", {out_valid2, out_s2, out_v2, out_c2}, {1'b1, e.s, e.v, e.c});
                    if (e.v && exp_cnt16 < 65535) exp_cnt16++;
                    if (e.v && exp_cnt2 < 3) exp_cnt2++;
                end
                got_s.push_back(out_s);
                got_v.push_back(out_v);
                got_c.push_back(out_c);
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_m));
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        got_s.delete();
        got_v.delete();
        got_c.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_m = m;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (got_s.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("wait_log", got_s.size() >= n, 1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream_s[4] = '{32'd30, 32'd76, 32'd5, 32'hFFFF_FFF5};
    logic        stream_c[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [31:0] sat_hi;
        logic [31:0] sat_lo;
`ifdef ADDSUB_SAT_EN
        sat_hi = 32'h7FFF_FFFF;
        sat_lo = 32'h8000_0000;
`else
        sat_hi = 32'h8000_0000;
        sat_lo = 32'h7FFF_FFFF;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'd7;
        in_b      = 32'd9;
        in_m      = 1'b0;
        out_ready = 1'b1;

        // Reset with a request pending: nothing may come out
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("reset_ovf", ovf_cnt, 0);
        check_eq("reset_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        check_eq("reset_no_emit", got_s.size(), 0);
        @(posedge clk);
        #1;

        // Back-to-back stream, full throughput
        clear_logs();
        send(32'd16, 32'd14, 1'b0);
        send(32'd32, 32'd44, 1'b0);
        send(32'd20, 32'd15, 1'b1);
        send(32'd14, 32'd25, 1'b1);
        wait_log(4);
        check_eq("stream_latency", got_cyc[0] - acc_cyc[0], 2);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("stream_s%0d", i), got_s[i], stream_s[i]);
            check_eq($sformatf("stream_c%0d", i), got_c[i], stream_c[i]);
            check_eq($sformatf("stream_v%0d", i), got_v[i], 0);
            check_eq($sformatf("stream_cyc%0d", i), got_cyc[i], got_cyc[0] + i);
        end

        // Back-pressure: fill both stages then stall
        clear_logs();
        out_ready = 1'b0;
        send(32'd30, 32'd12, 1'b1);
        send(32'd14, 32'd5, 1'b1);
        in_valid = 1'b1;
        in_a = 32'd1;
        in_b = 32'd1;
        in_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_in_ready_c2", in_ready2, 0);
            check_eq("bp_out_s", out_s, 32'd18);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_log(2);
        repeat (4) @(negedge clk);
        check_eq("bp_count", got_s.size(), 2);
        check_eq("bp_first", got_s[0], 32'd18);
        check_eq("bp_second", got_s[1], 32'd9);
        @(posedge clk);
        #1;

        // Signed overflow in both directions
        clear_logs();
        send(32'h7FFF_FFFF, 32'd1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1);
        wait_log(2);
        check_eq("ovf_add_s", got_s[0], sat_hi);
        check_eq("ovf_add_vc", {got_v[0], got_c[0]}, 2'b10);
        check_eq("ovf_sub_s", got_s[1], sat_lo);
        check_eq("ovf_sub_vc", {got_v[1], got_c[1]}, 2'b11);
        @(negedge clk);
        check_eq("ovf_cnt_2", ovf_cnt, 2);
        check_eq("ovf_cnt2_2", ovf_cnt2, 2);
        @(posedge clk);
        #1;

        // Counter saturation on the 2-bit instance
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) send(32'h7FFF_FFFF, 32'd1, 1'b0);
            else            send(32'h8000_0000, 32'd1, 1'b1);
        end
        wait_log(5);
        @(negedge clk);
        check_eq("sat_cnt2", ovf_cnt2, 3);
        check_eq("sat_cnt16", ovf_cnt, 7);
        @(posedge clk);
        #1;

        // Reset with both stages full, then a fresh op
        out_ready = 1'b0;
        send(32'd100, 32'd1, 1'b0);
        send(32'd200, 32'd2, 1'b0);
        clear_logs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = 32'd1;
        in_b = 32'd1;
        in_m = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("midrst_lat1", out_valid, 0);
        @(negedge clk);
        check_eq("midrst_lat2", {out_valid, out_s}, {1'b1, 32'd2});
        repeat (3) @(negedge clk);
        check_eq("midrst_count", got_s.size(), 1);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure against the scoreboard
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
